// File: rtl/dcache_wb_if.sv
// rtl/dcache_wb_if.sv - CPU-side and memory-side bus of the write-back data cache
interface dcache_wb_if;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [3:0]   write_mask;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, write, address, writedata, write_mask, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, write_mask, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// rtl/dcache_wb_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_wb_ctrl #(
  parameter int SETS = 8
) (
  input logic        CLK,
  input logic        RESET,
  dcache_wb_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SETS-1:0] r_valid;
  logic [SETS-1:0] r_dirty;
  logic [TW-1:0]   r_tag  [SETS];
  logic [127:0]    r_data [SETS];
  logic [27:0]     r_blk;

  logic [IW-1:0]   w_idx;
  logic [TW-1:0]   w_tag;
  logic [1:0]      w_off;
  logic [IW-1:0]   w_ridx;
  logic            w_req;
  logic            w_hit;
  logic [31:0]     w_word;
  logic            w_miss_start;
  logic            w_fill;
  logic            w_store;
  logic            w_unused;

  assign w_idx    = bus.address[4 +: IW];
  assign w_tag    = bus.address[31 -: TW];
  assign w_off    = bus.address[3:2];
  assign w_ridx   = r_blk[IW-1:0];
  assign w_req    = bus.read | bus.write;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word   = r_data[w_idx][{w_off, 5'b00000} +: 32];
  assign w_unused = ^bus.address[1:0];

  always_comb begin
    w_next            = r_state;
    w_miss_start      = 1'b0;
    w_fill            = 1'b0;
    w_store           = 1'b0;
    bus.busywait      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    bus.readdata      = '0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            // a simultaneous read+write is served as a store
            if (bus.write) w_store = 1'b1;
            else           bus.readdata = w_word;
          end else begin
            bus.busywait = 1'b1;
            w_miss_start = 1'b1;
            w_next       = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        bus.busywait      = 1'b1;
        bus.mem_write     = 1'b1;
        bus.mem_address   = {r_tag[w_ridx], w_ridx};
        bus.mem_writedata = r_data[w_ridx];
        if (!bus.mem_busywait) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        bus.busywait    = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_address = r_blk;
        if (!bus.mem_busywait) begin
          w_fill = 1'b1;
          w_next = UPDATE;
        end
      end
      UPDATE: begin
        bus.busywait = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // the miss block address is latched so a dropped request cannot disturb the transfer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_blk   <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss_start) r_blk <= bus.address[31:4];
      if (w_fill) begin
        r_valid[w_ridx] <= 1'b1;
        r_dirty[w_ridx] <= 1'b0;
      end
      if (w_store) r_dirty[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_data[w_ridx] <= bus.mem_readdata;
      r_tag[w_ridx]  <= r_blk[27 -: TW];
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.write_mask[2'(b)])
          r_data[w_idx][{w_off, 2'(b), 3'b000} +: 8] <= bus.writedata[{2'(b), 3'b000} +: 8];
      end
    end
  end
endmodule
